// File: rtl/twofish_dec_stream_if_pkg.sv
// Shared constants and state encoding for the Twofish byte-stream decrypt wrapper.
package twofish_pkg;
    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        EMIT
    } dec_if_state_t;
endpackage

// File: rtl/twofish_dec_stream_if_if.sv
// Ciphertext-in / plaintext-out byte stream bundle with valid/ready on each side.
interface twofish_dec_stream_if_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport slave  (input  s_data, s_valid, m_ready, output s_ready, m_data, m_valid);
    modport master (output s_data, s_valid, m_ready, input  s_ready, m_data, m_valid);
endinterface

// File: rtl/twofish_dec_stream_if_byte_shift_reg128.sv
// 128-bit register with parallel load and MSB-first byte shift; load wins over shift.
module byte_shift_reg128
    import twofish_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               shift_en,
    input  logic [7:0]         shift_in,
    output logic [BLOCK_W-1:0] data
);
    logic [BLOCK_W-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (load_en)
            data_d = load_data;
        else if (shift_en)
            data_d = {data_q[BLOCK_W-9:0], shift_in};
    end

    always_ff @(posedge clk) begin
        if (rst)
            data_q <= '0;
        else
            data_q <= data_d;
    end

    assign data = data_q;
endmodule

// File: rtl/twofish_dec_stream_if.sv
// Byte-stream wrapper around a combinational Twofish decryptor: deserialise 16 bytes,
// hold the core inputs for SETTLE_CYCLES, capture the plaintext and serialise it back out.
module twofish_dec_stream_if
    import twofish_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SETTLE_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_W-1:0]      key_in,
    input  logic                    key_load,
    twofish_dec_stream_if_if.slave  strm,
    output logic [BLOCK_W-1:0]      core_ct,
    output logic [BLOCK_W-1:0]      core_key,
    input  logic [BLOCK_W-1:0]      core_pt,
    output logic                    busy
);
    dec_if_state_t      state_q, state_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] pt_q;
    logic               s_ready_w, s_take, m_take, pt_load;
    logic               pt_unused;

    assign s_ready_w = (state_q == LOAD) & ~rst;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        settle_cnt_d = settle_cnt_q;
        key_d        = key_q;
        s_take       = 1'b0;
        m_take       = 1'b0;
        pt_load      = 1'b0;
        case (state_q)
            LOAD: begin
                // Key changes only between blocks so the core never sees a mixed key.
                if (key_load && byte_cnt_q == 4'd0)
                    key_d = key_in;
                if (strm.s_valid && s_ready_w) begin
                    s_take     = 1'b1;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd15) begin
                        state_d      = SETTLE;
                        settle_cnt_d = SETTLE_W'(SETTLE_CYCLES - 1);
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q == '0) begin
                    pt_load = 1'b1;
                    state_d = EMIT;
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end
            EMIT: begin
                if (strm.m_ready) begin
                    m_take     = 1'b1;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == 4'd15)
                        state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            byte_cnt_q   <= '0;
            settle_cnt_q <= '0;
            key_q        <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            key_q        <= key_d;
        end
    end

    byte_shift_reg128 u_ct_deser (
        .clk       (clk),
        .rst       (rst),
        .load_en   (1'b0),
        .load_data ('0),
        .shift_en  (s_take),
        .shift_in  (strm.s_data),
        .data      (core_ct)
    );

    byte_shift_reg128 u_pt_ser (
        .clk       (clk),
        .rst       (rst),
        .load_en   (pt_load),
        .load_data (core_pt),
        .shift_en  (m_take),
        .shift_in  (8'h00),
        .data      (pt_q)
    );

    // Only the top byte leaves the block; the rest just shifts up into it.
    assign pt_unused    = ^pt_q[BLOCK_W-9:0];

    assign core_key     = key_q;
    assign strm.s_ready = s_ready_w;
    assign strm.m_valid = (state_q == EMIT);
    assign strm.m_data  = pt_q[BLOCK_W-1:BLOCK_W-8];
    assign busy         = (state_q != LOAD);
endmodule

// File: tb/tb_twofish_dec_stream_if.sv
// Directed bench for the Twofish byte-stream wrapper with a stub decrypt core.
module tb_twofish_dec_stream_if;
    localparam int S = 4;
    localparam logic [127:0] KAT_CT  = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
    localparam logic [127:0] SEQ_CT  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] BP_CT   = 128'hDEADBEEF0123456789ABCDEFC0FFEE42;
    localparam logic [127:0] KEY_CT  = 128'h5A5A123487650F0FA1B2C3D4E5F60718;
    localparam logic [127:0] RST_CT  = 128'h1122334455667788990011223344AABB;
    localparam logic [127:0] K33     = {16{8'h33}};
    localparam logic [127:0] K11     = {16{8'h11}};

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic [127:0] core_ct, core_key, core_pt;
    logic         busy;
    int           checks = 0;
    int           errors = 0;

    twofish_dec_stream_if_if bus ();

    twofish_dec_stream_if #(.SETTLE_CYCLES(S), .SETTLE_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_load (key_load),
        .strm     (bus.slave),
        .core_ct  (core_ct),
        .core_key (core_key),
        .core_pt  (core_pt),
        .busy     (busy)
    );

    // Stand-in core: known-answer vector for key 0, otherwise an invertible stub.
    always_comb begin
        if (core_key == '0 && core_ct == KAT_CT)
            core_pt = '0;
        else
            core_pt = ~core_ct ^ core_key;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd, input bit kl, input logic [127:0] k);
        int guard;
        guard = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 1 && guard < 8) begin
                bus.s_valid = 1'b0;
                tick();
                guard++;
            end
        end
        guard       = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        key_load    = kl;
        key_in      = k;
        while (!bus.s_ready && guard < 100) begin
            tick();
            guard++;
        end
        check("s_ready_wait", {127'd0, guard < 100}, 128'd1);
        tick();
        bus.s_valid = 1'b0;
        key_load    = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] ct, input bit rnd);
        for (int i = 0; i < 16; i++)
            send_byte(ct[127-8*i -: 8], rnd, 1'b0, '0);
    endtask

    task automatic recv_block(input logic [127:0] exp, input logic [3:0] pat, input int stop_after);
        int i, p, cyc;
        i = 0; p = 0; cyc = 0;
        while (i < stop_after && cyc < 400) begin
            bus.m_ready = pat[3 - (p % 4)];
            p++;
            check("s_ready_busy", {127'd0, bus.s_ready}, 128'd0);
            if (bus.m_valid) begin
                check("m_data", {120'd0, bus.m_data}, {120'd0, exp[127-8*i -: 8]});
                if (bus.m_ready) i++;
            end
            tick();
            cyc++;
        end
        bus.m_ready = 1'b0;
        check("recv_timeout", {127'd0, cyc < 400}, 128'd1);
    endtask

    initial begin
        int cyc;
        rst         = 1'b1;
        key_in      = '0;
        key_load    = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;

        // Reset
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_s_ready", {127'd0, bus.s_ready}, 128'd0);
            check("rst_m_valid", {127'd0, bus.m_valid}, 128'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", {127'd0, bus.s_ready}, 128'd1);
        check("post_rst_busy", {127'd0, busy}, 128'd0);
        check("post_rst_m_data", {120'd0, bus.m_data}, 128'd0);
        check("post_rst_core_ct", core_ct, 128'd0);
        check("post_rst_core_key", core_key, 128'd0);

        // Sequential bytes with key 0, latency measurement
        send_byte(8'h00, 1'b0, 1'b1, '0);
        for (int i = 1; i < 16; i++)
            send_byte(SEQ_CT[127-8*i -: 8], 1'b0, 1'b0, '0);
        check("seq_core_ct", core_ct, SEQ_CT);
        cyc = 0;
        while (!bus.m_valid && cyc < 50) begin
            check("settle_busy", {127'd0, busy}, 128'd1);
            check("settle_s_ready", {127'd0, bus.s_ready}, 128'd0);
            tick();
            cyc++;
        end
        check("latency", 128'(cyc), 128'(S));
        recv_block(~SEQ_CT, 4'b1111, 16);
        check("seq_back_to_load", {127'd0, busy}, 128'd0);

        // Known-answer block, key 0
        send_block(KAT_CT, 1'b0);
        recv_block(128'd0, 4'b1111, 16);

        // Backpressure with random source gaps and a persistent s_valid during SETTLE/EMIT
        send_block(BP_CT, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        recv_block(~BP_CT, 4'b1001, 16);
        bus.s_valid = 1'b0;
        check("bp_core_ct_held", core_ct, BP_CT);

        // key_load accepted with first byte, ignored mid-block
        for (int i = 0; i < 16; i++) begin
            if (i == 0)
                send_byte(KEY_CT[127 -: 8], 1'b0, 1'b1, K33);
            else if (i == 5)
                send_byte(KEY_CT[127-8*i -: 8], 1'b0, 1'b1, K11);
            else
                send_byte(KEY_CT[127-8*i -: 8], 1'b0, 1'b0, '0);
            if (i == 0) begin
                check("kl_first_key", core_key, K33);
                check("kl_first_byte", {120'd0, core_ct[7:0]}, {120'd0, KEY_CT[127 -: 8]});
            end
            if (i == 5)
                check("kl_ignored", core_key, K33);
        end
        recv_block(~KEY_CT ^ K33, 4'b1111, 16);

        // Reset in the middle of EMIT, then a fresh block
        send_block(RST_CT, 1'b0);
        recv_block(~RST_CT ^ K33, 4'b1111, 7);
        rst = 1'b1;
        tick();
        check("mid_rst_m_valid", {127'd0, bus.m_valid}, 128'd0);
        check("mid_rst_s_ready", {127'd0, bus.s_ready}, 128'd0);
        check("mid_rst_busy", {127'd0, busy}, 128'd0);
        check("mid_rst_core_key", core_key, 128'd0);
        check("mid_rst_core_ct", core_ct, 128'd0);
        check("mid_rst_m_data", {120'd0, bus.m_data}, 128'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_s_ready_after", {127'd0, bus.s_ready}, 128'd1);
        send_byte(KAT_CT[127 -: 8], 1'b0, 1'b1, '0);
        for (int i = 1; i < 16; i++)
            send_byte(KAT_CT[127-8*i -: 8], 1'b0, 1'b0, '0);
        check("fresh_core_ct", core_ct, KAT_CT);
        recv_block(128'd0, 4'b1111, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
